// File: rtl/item_ram_arbiter.sv
// Single-port item RAM arbiter: renderer plus two rope controllers, one grant per cycle,
// with read tags pipelined alongside the RAM so each read word returns to its issuer.
module item_ram_arbiter #(
    parameter int RAM_LATENCY = 2,
    parameter int MAX_STARVE  = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        draw_req,
    input  logic [3:0]  draw_addr,
    input  logic [1:0]  rope_req,
    input  logic [1:0]  rope_we,
    input  logic [7:0]  rope_addr,
    input  logic [63:0] rope_wdata,
    output logic        draw_grant,
    output logic [1:0]  rope_grant,
    output logic        draw_rvalid,
    output logic [1:0]  rope_rvalid,
    output logic [31:0] rdata,
    output logic [3:0]  ram_address,
    output logic [31:0] ram_data,
    output logic        ram_wren,
    input  logic [31:0] ram_q
);

    localparam logic [1:0] SRC_DRAW  = 2'd0;
    localparam logic [1:0] SRC_ROPE0 = 2'd1;
    localparam logic [1:0] SRC_ROPE1 = 2'd2;
    localparam logic [3:0] STARVE_MAX = 4'(MAX_STARVE);

    typedef struct packed {
        logic       vld;
        logic [1:0] src;
    } tag_t;

    logic [1:0][3:0]  r_addr;
    logic [1:0][31:0] r_wdata;
    logic [3:0]       starve_cnt;
    logic             rr;
    logic [3:0]       last_addr;
    tag_t [RAM_LATENCY-1:0] tag_pipe;
    tag_t             tag_in;
    tag_t             tail;
    logic             rope_any;
    logic             forced;
    logic             rope_sel;

    assign r_addr  = rope_addr;
    assign r_wdata = rope_wdata;

    // Arbitration: forced rope slot, then renderer, then round-robin ropes.
    always_comb begin
        draw_grant = 1'b0;
        rope_grant = 2'b00;
        rope_any   = |rope_req;
        forced     = rope_any && (starve_cnt == STARVE_MAX);
        rope_sel   = (rope_req == 2'b11) ? rr : rope_req[1];
        if (!reset) begin
            if (forced || (!draw_req && rope_any))
                rope_grant = rope_sel ? 2'b10 : 2'b01;
            else if (draw_req)
                draw_grant = 1'b1;
        end
    end

    // Address holds its last value on idle cycles so the RAM keeps seeing a stable index.
    always_comb begin
        ram_wren    = 1'b0;
        ram_data    = 32'd0;
        ram_address = reset ? 4'd0 : last_addr;
        if (rope_grant != 2'b00) begin
            ram_address = r_addr[rope_sel];
            ram_data    = r_wdata[rope_sel];
            ram_wren    = rope_we[rope_sel];
        end else if (draw_grant) begin
            ram_address = draw_addr;
        end
    end

    always_comb begin
        tag_in.vld = draw_grant || ((rope_grant != 2'b00) && !rope_we[rope_sel]);
        tag_in.src = draw_grant ? SRC_DRAW : (rope_sel ? SRC_ROPE1 : SRC_ROPE0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt <= 4'd0;
            rr         <= 1'b0;
            last_addr  <= 4'd0;
            tag_pipe   <= '0;
        end else begin
            last_addr <= ram_address;
            if (rope_grant != 2'b00) begin
                rr         <= ~rope_sel;
                starve_cnt <= 4'd0;
            end else if (!rope_any) begin
                starve_cnt <= 4'd0;
            end else if (draw_grant && (starve_cnt < STARVE_MAX)) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
            tag_pipe[0] <= tag_in;
            for (int i = 1; i < RAM_LATENCY; i++)
                tag_pipe[i] <= tag_pipe[i-1];
        end
    end

    // Tail of the tag pipe lines up with ram_q for the access granted RAM_LATENCY cycles ago.
    assign tail           = tag_pipe[RAM_LATENCY-1];
    assign draw_rvalid    = !reset && tail.vld && (tail.src == SRC_DRAW);
    assign rope_rvalid[0] = !reset && tail.vld && (tail.src == SRC_ROPE0);
    assign rope_rvalid[1] = !reset && tail.vld && (tail.src == SRC_ROPE1);
    assign rdata          = ram_q;

endmodule

// File: tb/tb_item_ram_arbiter.sv
// Directed bench for item_ram_arbiter with a 2-cycle registered-address/registered-q RAM model.
module tb_item_ram_arbiter;

    logic        clock;
    logic        reset;
    logic        draw_req;
    logic [3:0]  draw_addr;
    logic [1:0]  rope_req;
    logic [1:0]  rope_we;
    logic [7:0]  rope_addr;
    logic [63:0] rope_wdata;
    logic        draw_grant;
    logic [1:0]  rope_grant;
    logic        draw_rvalid;
    logic [1:0]  rope_rvalid;
    logic [31:0] rdata;
    logic [3:0]  ram_address;
    logic [31:0] ram_data;
    logic        ram_wren;
    logic [31:0] ram_q;

    int errors;
    int checks;

    item_ram_arbiter #(.RAM_LATENCY(2), .MAX_STARVE(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .draw_req    (draw_req),
        .draw_addr   (draw_addr),
        .rope_req    (rope_req),
        .rope_we     (rope_we),
        .rope_addr   (rope_addr),
        .rope_wdata  (rope_wdata),
        .draw_grant  (draw_grant),
        .rope_grant  (rope_grant),
        .draw_rvalid (draw_rvalid),
        .rope_rvalid (rope_rvalid),
        .rdata       (rdata),
        .ram_address (ram_address),
        .ram_data    (ram_data),
        .ram_wren    (ram_wren),
        .ram_q       (ram_q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // RAM model: registered address, registered q
    logic [31:0] mem [16];
    logic [3:0]  addr_r;
    logic [31:0] q_r;
    always @(posedge clock) begin
        if (ram_wren) mem[ram_address] <= ram_data;
        addr_r <= ram_address;
        q_r    <= mem[addr_r];
    end
    assign ram_q = q_r;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        draw_req   = 1'b0;
        draw_addr  = 4'd0;
        rope_req   = 2'b00;
        rope_we    = 2'b00;
        rope_addr  = 8'd0;
        rope_wdata = 64'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[5] = 32'h1234_5678;
        mem[7] = 32'hCAFE_F00D;

        // Reset with every requester active: nothing may be granted.
        reset      = 1'b1;
        draw_req   = 1'b1;
        draw_addr  = 4'd5;
        rope_req   = 2'b11;
        rope_we    = 2'b01;
        rope_addr  = 8'h21;
        rope_wdata = {32'h1111_1111, 32'h2222_2222};
        next_cycle();
        @(negedge clock);
        chk("rst_draw_grant", 32'(draw_grant), 0);
        chk("rst_rope_grant", 32'(rope_grant), 0);
        chk("rst_wren", 32'(ram_wren), 0);
        chk("rst_address", 32'(ram_address), 0);
        chk("rst_data", ram_data, 0);
        chk("rst_rvalid", 32'({draw_rvalid, rope_rvalid}), 0);
        next_cycle();
        reset = 1'b0;
        idle_inputs();
        @(negedge clock);
        chk("post_rst_rvalid", 32'({draw_rvalid, rope_rvalid}), 0);
        chk("post_rst_address", 32'(ram_address), 0);
        chk("post_rst_wren", 32'(ram_wren), 0);

        // Renderer read of addr 5: grant in 0, data in 2 for one cycle.
        next_cycle();
        draw_req  = 1'b1;
        draw_addr = 4'd5;
        @(negedge clock);
        chk("t1_draw_grant", 32'(draw_grant), 1);
        chk("t1_rope_grant", 32'(rope_grant), 0);
        chk("t1_address", 32'(ram_address), 5);
        chk("t1_wren", 32'(ram_wren), 0);
        chk("t1_data", ram_data, 0);
        next_cycle();
        idle_inputs();
        @(negedge clock);
        chk("t1_rvalid_c1", 32'(draw_rvalid), 0);
        chk("t1_addr_hold", 32'(ram_address), 5);
        next_cycle();
        @(negedge clock);
        chk("t1_rvalid_c2", 32'(draw_rvalid), 1);
        chk("t1_rdata_c2", rdata, 32'h1234_5678);
        chk("t1_rope_rvalid_c2", 32'(rope_rvalid), 0);
        next_cycle();
        @(negedge clock);
        chk("t1_rvalid_c3", 32'(draw_rvalid), 0);

        // Player 0 writes addr 3, player 1 reads it back next cycle.
        next_cycle();
        rope_req   = 2'b01;
        rope_we    = 2'b01;
        rope_addr  = {4'h0, 4'h3};
        rope_wdata = {32'h0, 32'hA5A5_0003};
        @(negedge clock);
        chk("t2_rope_grant_c0", 32'(rope_grant), 32'b01);
        chk("t2_wren_c0", 32'(ram_wren), 1);
        chk("t2_address_c0", 32'(ram_address), 3);
        chk("t2_data_c0", ram_data, 32'hA5A5_0003);
        next_cycle();
        rope_req   = 2'b10;
        rope_we    = 2'b00;
        rope_addr  = {4'h3, 4'h0};
        rope_wdata = 64'd0;
        @(negedge clock);
        chk("t2_rope_grant_c1", 32'(rope_grant), 32'b10);
        chk("t2_wren_c1", 32'(ram_wren), 0);
        chk("t2_address_c1", 32'(ram_address), 3);
        next_cycle();
        idle_inputs();
        @(negedge clock);
        chk("t2_wren_c2", 32'(ram_wren), 0);
        chk("t2_rvalid_c2", 32'(rope_rvalid), 0);
        next_cycle();
        @(negedge clock);
        chk("t2_rvalid_c3", 32'(rope_rvalid), 32'b10);
        chk("t2_rdata_c3", rdata, 32'hA5A5_0003);
        chk("t2_draw_rvalid_c3", 32'(draw_rvalid), 0);

        // Both ropes reading continuously: alternate starting with player 0.
        next_cycle();
        do_reset();
        rope_req  = 2'b11;
        rope_addr = {4'h2, 4'h1};
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk($sformatf("t3_rr_%0d", i), 32'(rope_grant), (i % 2 == 1) ? 32'b10 : 32'b01);
            chk($sformatf("t3_draw_%0d", i), 32'(draw_grant), 0);
            next_cycle();
        end
        idle_inputs();
        for (int i = 0; i < 3; i++) next_cycle();

        // Renderer vs player 1: 8 renderer wins, forced rope slot, then repeat.
        do_reset();
        draw_req  = 1'b1;
        draw_addr = 4'd5;
        rope_req  = 2'b10;
        rope_addr = {4'h7, 4'h0};
        for (int i = 0; i < 18; i++) begin
            @(negedge clock);
            chk($sformatf("t4_rope_%0d", i), 32'(rope_grant), (i == 8 || i == 17) ? 32'b10 : 32'b00);
            chk($sformatf("t4_draw_%0d", i), 32'(draw_grant), (i == 8 || i == 17) ? 32'd0 : 32'd1);
            next_cycle();
        end
        idle_inputs();
        for (int i = 0; i < 3; i++) next_cycle();

        // Back-to-back reads from three requesters return in grant order.
        draw_req  = 1'b1;
        draw_addr = 4'd5;
        @(negedge clock);
        chk("t5_grant_c0", 32'(draw_grant), 1);
        next_cycle();
        idle_inputs();
        rope_req  = 2'b01;
        rope_addr = {4'h0, 4'h3};
        @(negedge clock);
        chk("t5_grant_c1", 32'(rope_grant), 32'b01);
        next_cycle();
        rope_req  = 2'b10;
        rope_addr = {4'h7, 4'h3};
        @(negedge clock);
        chk("t5_grant_c2", 32'(rope_grant), 32'b10);
        chk("t5_draw_rvalid_c2", 32'(draw_rvalid), 1);
        chk("t5_rope_rvalid_c2", 32'(rope_rvalid), 0);
        chk("t5_rdata_c2", rdata, 32'h1234_5678);
        next_cycle();
        idle_inputs();
        @(negedge clock);
        chk("t5_rope_rvalid_c3", 32'(rope_rvalid), 32'b01);
        chk("t5_draw_rvalid_c3", 32'(draw_rvalid), 0);
        chk("t5_rdata_c3", rdata, 32'hA5A5_0003);
        next_cycle();
        @(negedge clock);
        chk("t5_rope_rvalid_c4", 32'(rope_rvalid), 32'b10);
        chk("t5_rdata_c4", rdata, 32'hCAFE_F00D);
        next_cycle();
        @(negedge clock);
        chk("t5_rvalid_c5", 32'({draw_rvalid, rope_rvalid}), 0);

        // Reset while a read is in flight: its tag must be dropped.
        next_cycle();
        draw_req  = 1'b1;
        draw_addr = 4'd5;
        @(negedge clock);
        chk("t6_grant_c0", 32'(draw_grant), 1);
        next_cycle();
        idle_inputs();
        reset = 1'b1;
        @(negedge clock);
        chk("t6_grant_c1", 32'({draw_grant, rope_grant}), 0);
        chk("t6_address_c1", 32'(ram_address), 0);
        next_cycle();
        reset = 1'b0;
        @(negedge clock);
        chk("t6_rvalid_c2", 32'({draw_rvalid, rope_rvalid}), 0);
        chk("t6_wren_c2", 32'(ram_wren), 0);
        chk("t6_address_c2", 32'(ram_address), 0);
        chk("t6_data_c2", ram_data, 0);
        next_cycle();
        @(negedge clock);
        chk("t6_rvalid_c3", 32'({draw_rvalid, rope_rvalid}), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/item_ram_arbiter.md
# item_ram_arbiter

Shares the single-port 16×32 item RAM (stone/gold/diamond records) between three requesters: the stone renderer and up to two rope controllers (one per player in two-player mode). It grants one access per cycle and drives the RAM address, data and write-enable. It tracks in-flight reads and returns each read word to the requester that issued it. It replaces the ad-hoc `draw_stone_flag ? draw_index : rope_index` address mux, so ropes no longer stall-poll on the renderer.

## Interface
Parameters:
- `RAM_LATENCY`, default 2: cycles from address sampled to `ram_q` valid (registered address + registered q); legal 1–4.
- `MAX_STARVE`, default 8: consecutive renderer-won cycles with a rope waiting before that rope gets a forced slot.

Ports:
- `clock` in 1: system clock; all state on rising edge.
- `reset` in 1: synchronous, active-high.
- `draw_req` in 1: renderer read request (read-only requester, index 0).
- `draw_addr` in 4: renderer item index.
- `rope_req` in 2: rope request, bit0 = player 0, bit1 = player 1.
- `rope_we` in 2: 1 = write, 0 = read, per rope.
- `rope_addr` in 8: {player1[3:0], player0[3:0]}.
- `rope_wdata` in 64: {player1[31:0], player0[31:0]}.
- `draw_grant` out 1: renderer request accepted this cycle.
- `rope_grant` out 2: rope request accepted this cycle.
- `draw_rvalid` out 1: `rdata` holds renderer's read result.
- `rope_rvalid` out 2: `rdata` holds that rope's read result.
- `rdata` out 32: read return bus (= `ram_q`).
- `ram_address` out 4, `ram_data` out 32, `ram_wren` out 1: RAM port.
- `ram_q` in 32: RAM read data.

## Operation
- Requester holds req/addr/we/wdata stable until it sees its grant. The grant is combinational in the same cycle, and the access is issued at that cycle's closing edge. Requester may drop req or present a new request the cycle after the grant.
- At most one grant per cycle. Priority:
  1. Forced rope slot, when the starve counter = `MAX_STARVE` and a rope is requesting.
  2. `draw_req`.
  3. Ropes, round-robin.
- Round-robin pointer `rr` (1 bit) names the preferred rope. If both ropes request, the preferred rope wins. After any rope grant, `rr` ← the non-granted rope index. If only one rope requests, it wins regardless of `rr`.
- Starve counter (4 bit, saturating at `MAX_STARVE`):
  - +1 each cycle the renderer is granted while `rope_req != 0`.
  - Cleared on any rope grant.
  - Cleared when `rope_req == 0`.
- RAM port:
  - `ram_address` = winner's address.
  - `ram_data` = winning rope's wdata; 0 when renderer wins.
  - `ram_wren` = 1 only for a granted rope write.
  - When there is no grant: address holds its last value, `ram_wren` = 0.
- Read tagging: a `RAM_LATENCY`-deep shift register of {valid, source[1:0]}, loaded each cycle (valid=1 only for a granted read). At the tail, exactly one of `draw_rvalid` / `rope_rvalid[n]` pulses for one cycle. Writes produce no rvalid.
- A read of an address written in an earlier cycle returns the new data. Same-cycle conflict cannot occur (one grant per cycle).

## Timing
- Grant cycle N; read data and rvalid in cycle N+`RAM_LATENCY`. Fully pipelined: one access per cycle, back-to-back reads from different requesters return in grant order.
- Write committed at the edge ending cycle N; a read granted in N+1 sees it.
- Reset values (while `reset`=1 and the cycle after): all grants 0, all rvalid 0, `ram_wren` 0, `ram_address` 0, `ram_data` 0, `rr` = 0 (player 0 preferred), starve counter 0, tag pipe cleared.
- Reset asserted mid-read: in-flight tags are discarded, and no rvalid pulses after reset even though `ram_q` changes.
- Requests presented during reset are not granted. Arbitration starts on the first cycle with `reset`=0.
- All three requesting simultaneously with counter < `MAX_STARVE`: renderer wins, counter +1.

## Test plan
- Reset, then `draw_req`=1, `draw_addr`=5, RAM[5]=0x12345678 → `draw_grant`=1 in cycle 0. `draw_rvalid`=1 with `rdata`=0x12345678 in cycle 2, for exactly one cycle.
- Player 0 writes 0xA5A5_0003 to addr 3 at cycle 0, then player 1 reads addr 3 at cycle 1 → `ram_wren` pulses cycle 0 only. `rope_rvalid`=2'b10 at cycle 3 with `rdata`=0xA5A5_0003.
- Both ropes read continuously, no renderer → grants alternate 01,10,01,10 starting with 01 after reset.
- Renderer and player 1 requesting continuously → 8 renderer grants, then `rope_grant`=2'b10 on the 9th cycle, then renderer again; counter restarts.
- Mixed reads at cycles 0,1,2 (draw, rope0, rope1) → rvalids at 2,3,4 in that order with the matching data.
- Grant a read at cycle 0, assert `reset` in cycle 1 → no rvalid in cycles 2–3; all outputs at reset values.
